// File: rtl/hazard_unit.sv
// Hazard/forwarding unit plus divide sequencer; forwarding and stalls are combinational, divide state is registered.
// No handshake: it holds F/D/E through stall outputs, and divdoneE pulses in the release cycle of each divide.
module hazard_unit #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       memtoregM,
    input  logic       branchD,
    input  logic       divstartE,
    output logic       forwardaD,
    output logic       forwardbD,
    output logic [1:0] forwardaE,
    output logic [1:0] forwardbE,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushE,
    output logic       divbusy,
    output logic       divdoneE
);

    typedef enum logic {IDLE, BUSY} div_state_t;

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic lwstall;
    logic branchstall;
    logic divstall;
    logic cnt_zero;

    // The M stage holds the newer value, so it wins over W.
    always_comb begin
        forwardaE = 2'b00;
        if (rsE != 5'd0 && rsE == writeregM && regwriteM)
            forwardaE = 2'b10;
        else if (rsE != 5'd0 && rsE == writeregW && regwriteW)
            forwardaE = 2'b01;

        forwardbE = 2'b00;
        if (rtE != 5'd0 && rtE == writeregM && regwriteM)
            forwardbE = 2'b10;
        else if (rtE != 5'd0 && rtE == writeregW && regwriteW)
            forwardbE = 2'b01;
    end

    assign forwardaD = (rsD != 5'd0) && (rsD == writeregM) && regwriteM;
    assign forwardbD = (rtD != 5'd0) && (rtD == writeregM) && regwriteM;

    assign lwstall = memtoregE && ((rsD == rtE) || (rtD == rtE));

    assign branchstall = branchD &&
        ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
         (memtoregM && (writeregM == rsD || writeregM == rtD)));

    assign cnt_zero = (cnt_q == '0);

    // The start cycle counts as a stall cycle; the final cnt==0 cycle lets E advance.
    assign divstall = !rst &&
        (((state_q == IDLE) && divstartE) || ((state_q == BUSY) && !cnt_zero));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (divstartE) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(DIV_CYCLES - 1);
                end
            end
            BUSY: begin
                if (!cnt_zero)
                    cnt_d = cnt_q - CNT_W'(1);
                else
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stallF   = lwstall || branchstall || divstall;
    assign stallD   = lwstall || branchstall || divstall;
    assign stallE   = divstall;
    // A held E stage must keep its instruction, so the bubble waits for release.
    assign flushE   = (lwstall || branchstall) && !divstall;
    assign divbusy  = (state_q == BUSY);
    assign divdoneE = (state_q == BUSY) && cnt_zero;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit with DIV_CYCLES=4.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, divstartE;
    logic       forwardaD, forwardbD;
    logic [1:0] forwardaE, forwardbE;
    logic       stallF, stallD, stallE, flushE, divbusy, divdoneE;

    int checks = 0;
    int errors = 0;
    logic [11:0] sb_q[$];

    always #5 clk = ~clk;

    hazard_unit #(.DIV_CYCLES(4), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .divstartE(divstartE),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushE(flushE),
        .divbusy(divbusy), .divdoneE(divdoneE)
    );

    // Expected vector order: fad fbd faE[1:0] fbE[1:0] sF sD sE flE busy done
    task automatic expect_out(input logic fad, input logic fbd, input logic [1:0] fae,
                              input logic [1:0] fbe, input logic sf, input logic sd,
                              input logic se, input logic fe, input logic db,
                              input logic dd);
        sb_q.push_back({fad, fbd, fae, fbe, sf, sd, se, fe, db, dd});
    endtask

    task automatic check(input string tag);
        logic [11:0] obs;
        logic [11:0] exp;
        @(negedge clk);
        obs = {forwardaD, forwardbD, forwardaE, forwardbE,
               stallF, stallD, stallE, flushE, divbusy, divdoneE};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            exp = sb_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; memtoregM = 0; branchD = 0; divstartE = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        clr();
        expect_out(0,0,2'b00,2'b00,0,0,0,0,0,0); check("reset");
        next_cycle(); rst = 1'b0;

        // Forwarding priority and $0 suppression
        rsE = 5; writeregM = 5; regwriteM = 1; writeregW = 5; regwriteW = 1;
        expect_out(0,0,2'b10,2'b00,0,0,0,0,0,0); check("fwd_m_prio");
        next_cycle(); regwriteM = 0;
        expect_out(0,0,2'b01,2'b00,0,0,0,0,0,0); check("fwd_w");
        next_cycle(); rsE = 0; regwriteM = 1;
        expect_out(0,0,2'b00,2'b00,0,0,0,0,0,0); check("fwd_r0");
        next_cycle(); clr(); rtE = 9; writeregW = 9; regwriteW = 1;
        rtD = 9; writeregM = 9; regwriteM = 1;
        expect_out(0,1,2'b00,2'b10,0,0,0,0,0,0); check("fwd_b_path");
        next_cycle(); regwriteM = 0;
        expect_out(0,0,2'b00,2'b01,0,0,0,0,0,0); check("fwd_b_w");

        // Load-use
        next_cycle(); clr(); memtoregE = 1; rtE = 8; rsD = 8;
        expect_out(0,0,2'b00,2'b00,1,1,0,1,0,0); check("lwstall");
        next_cycle(); memtoregE = 0;
        expect_out(0,0,2'b00,2'b00,0,0,0,0,0,0); check("lw_clear");

        // Branch hazards
        next_cycle(); clr(); branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3;
        expect_out(0,0,2'b00,2'b00,1,1,0,1,0,0); check("br_e");
        next_cycle(); regwriteE = 0; memtoregM = 1; writeregM = 3;
        expect_out(0,0,2'b00,2'b00,1,1,0,1,0,0); check("br_m_load");
        next_cycle(); memtoregM = 0; regwriteM = 1;
        expect_out(1,0,2'b00,2'b00,0,0,0,0,0,0); check("br_m_fwd");

        // $0 load-use still stalls but never forwards
        next_cycle(); clr(); memtoregE = 1; regwriteM = 1;
        expect_out(0,0,2'b00,2'b00,1,1,0,1,0,0); check("r0_stall");

        // Divide timing
        next_cycle(); clr(); divstartE = 1;
        expect_out(0,0,2'b00,2'b00,1,1,1,0,0,0); check("div_c0");
        for (int c = 1; c < 4; c++) begin
            next_cycle();
            expect_out(0,0,2'b00,2'b00,1,1,1,0,1,0); check($sformatf("div_c%0d", c));
        end
        next_cycle();
        expect_out(0,0,2'b00,2'b00,0,0,0,0,1,1); check("div_done");
        divstartE = 0;
        next_cycle();
        expect_out(0,0,2'b00,2'b00,0,0,0,0,0,0); check("div_idle");

        // Reset mid-divide
        next_cycle(); divstartE = 1;
        expect_out(0,0,2'b00,2'b00,1,1,1,0,0,0); check("rdiv_c0");
        next_cycle();
        expect_out(0,0,2'b00,2'b00,1,1,1,0,1,0); check("rdiv_c1");
        next_cycle(); rst = 1'b1;
        expect_out(0,0,2'b00,2'b00,0,0,0,0,0,0); check("rdiv_rst");
        next_cycle(); rst = 1'b0;
        expect_out(0,0,2'b00,2'b00,1,1,1,0,0,0); check("rdiv2_c0");
        for (int c = 1; c < 4; c++) begin
            next_cycle();
            expect_out(0,0,2'b00,2'b00,1,1,1,0,1,0); check($sformatf("rdiv2_c%0d", c));
        end
        next_cycle();
        expect_out(0,0,2'b00,2'b00,0,0,0,0,1,1); check("rdiv2_done");
        divstartE = 0;

        // Divide overlapping a load-use hazard
        next_cycle(); divstartE = 1;
        expect_out(0,0,2'b00,2'b00,1,1,1,0,0,0); check("dlw_c0");
        next_cycle(); memtoregE = 1; rtE = 8; rsD = 8;
        expect_out(0,0,2'b00,2'b00,1,1,1,0,1,0); check("dlw_c1");
        for (int c = 2; c < 4; c++) begin
            next_cycle();
            expect_out(0,0,2'b00,2'b00,1,1,1,0,1,0); check($sformatf("dlw_c%0d", c));
        end
        next_cycle();
        expect_out(0,0,2'b00,2'b00,1,1,0,1,1,1); check("dlw_done");
        clr();
        next_cycle();
        expect_out(0,0,2'b00,2'b00,0,0,0,0,0,0); check("dlw_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
